// File: rtl/seq_bcd_calculator.sv
// seq_bcd_calculator: 2*OP_DIGITS-digit button calculator with a multi-cycle
// add/sub/mul/div engine, double-dabble binary->BCD conversion and a
// multiplexed active-low 7-segment display.
// Optional feature macro: CALC_REMAINDER_EN. When it is defined, a divide shows
// the quotient in the left half and the remainder in the right half.
// Handshake: go/clr/in are level buttons; they act on the rising edge of their
// synchronised copy. busy rises the cycle after go is accepted and falls in the
// same cycle that the result becomes visible.
module seq_bcd_calculator #(
    parameter int OP_DIGITS   = 2,
    parameter int REFRESH_DIV = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [2*OP_DIGITS-1:0] in,
    input  logic [1:0]             op,
    input  logic                   go,
    input  logic                   clr,
    output logic                   busy,
    output logic                   neg,
    output logic                   err,
    output logic [6:0]             seg,
    output logic [2*OP_DIGITS-1:0] an
);
    localparam int ND  = 2 * OP_DIGITS;
    localparam int HW  = 4 * OP_DIGITS;
    localparam int BW  = 4 * ND;
    localparam int OPW = $clog2(10 ** OP_DIGITS);
    localparam int RW  = 2 * OPW;
    localparam int CW  = $clog2(RW + 1);
    localparam int NI  = ND + 2;
    localparam int RCW = $clog2(REFRESH_DIV);
    localparam int SCW = $clog2(ND);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {S_EDIT, S_LOAD, S_EXEC, S_B2D, S_SHOW} state_t;

    state_t                         state_q;
    logic [SYNC_STAGES-1:0][NI-1:0] sync_q;
    logic [NI-1:0]                  prev_q;
    logic [NI-1:0]                  edge_d;
    logic [ND-1:0]                  in_edge;
    logic                           go_edge, clr_edge;
    logic [BW-1:0]                  digits_q, digits_d;
    logic [1:0]                     op_q;
    logic [OPW-1:0]                 a_q, b_q, rem_q;
    logic [OPW-1:0]                 a_bin, b_bin;
    logic [RW-1:0]                  acc_q, mc_q, bin_q;
`ifdef CALC_REMAINDER_EN
    logic [RW-1:0]                  bin2_q;
`endif
    logic [CW-1:0]                  cnt_q;
    logic [BW-1:0]                  bcd_q;
    logic                           busy_q, neg_q, err_q;
    logic [OPW:0]                   div_sh;
    logic                           div_ge;
    logic [OPW-1:0]                 div_sub;
    logic [RCW-1:0]                 refresh_q;
    logic [SCW-1:0]                 scan_q;
    logic [3:0]                     cur_digit;
    logic                           dash;

    // Horner evaluation of an operand's BCD digits into binary
    function automatic logic [OPW-1:0] bcd_to_bin(input logic [HW-1:0] d);
        logic [RW-1:0] v;
        v = '0;
        for (int i = OP_DIGITS - 1; i >= 0; i--) v = v * RW'(10) + RW'(d[4*i +: 4]);
        return v[OPW-1:0];
    endfunction

    // One double-dabble step; with split set the two halves shift independently
    function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] b, input logic hi_bit,
                                              input logic lo_bit, input logic split);
        logic [BW-1:0] a;
        a = b;
        for (int i = 0; i < ND; i++) if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        dd_step = {a[BW-2:0], lo_bit};
        if (split) dd_step[HW] = hi_bit;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return SEG_BLANK;
        endcase
    endfunction

    // Synchronise the buttons and keep the previous synchronised level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {clr, go, in}};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_d   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign in_edge  = edge_d[ND-1:0];
    assign go_edge  = edge_d[ND];
    assign clr_edge = edge_d[ND+1];
    assign a_bin    = bcd_to_bin(digits_q[BW-1:HW]);
    assign b_bin    = bcd_to_bin(digits_q[HW-1:0]);
    assign div_sh   = {rem_q, acc_q[OPW-1]};
    assign div_ge   = (div_sh >= {1'b0, b_q});
    assign div_sub  = div_sh[OPW-1:0] - b_q;

    // Digit increments (mod 10) requested by this cycle's button edges
    always_comb begin
        digits_d = digits_q;
        for (int i = 0; i < ND; i++)
            if (in_edge[i])
                digits_d[4*i +: 4] = (digits_q[4*i +: 4] >= 4'd9) ? 4'd0 : digits_q[4*i +: 4] + 4'd1;
    end

    // Control FSM with arithmetic engine and BCD converter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_EDIT; digits_q <= '0; op_q <= OP_ADD;
            a_q <= '0; b_q <= '0; rem_q <= '0; acc_q <= '0; mc_q <= '0; bin_q <= '0;
`ifdef CALC_REMAINDER_EN
            bin2_q <= '0;
`endif
            cnt_q <= '0; bcd_q <= '0; busy_q <= 1'b0; neg_q <= 1'b0; err_q <= 1'b0;
        end else if (clr_edge) begin
            state_q <= S_EDIT; digits_q <= '0; bcd_q <= '0;
            busy_q <= 1'b0; neg_q <= 1'b0; err_q <= 1'b0;
        end else begin
            case (state_q)
                S_EDIT, S_SHOW: begin
                    digits_q <= digits_d;
                    if (|in_edge) begin
                        state_q <= S_EDIT;
                        err_q   <= 1'b0;
                    end
                    if (go_edge) begin
                        state_q <= S_LOAD; busy_q <= 1'b1;
                        neg_q <= 1'b0; err_q <= 1'b0; op_q <= op;
                    end
                end
                S_LOAD: begin
                    a_q <= a_bin; b_q <= b_bin; mc_q <= RW'(a_bin);
                    acc_q <= (op_q == 2'b11) ? RW'(a_bin) : '0;
                    rem_q <= '0; cnt_q <= '0; state_q <= S_EXEC;
                end
                S_EXEC: begin
                    bcd_q <= '0;
                    cnt_q <= cnt_q + CW'(1);
                    case (op_q)
                        OP_ADD: begin
                            bin_q <= RW'(a_q) + RW'(b_q); cnt_q <= '0; state_q <= S_B2D;
                        end
                        OP_SUB: begin
                            if (a_q < b_q) begin
                                bin_q <= RW'(b_q - a_q); neg_q <= 1'b1;
                            end else begin
                                bin_q <= RW'(a_q - b_q);
                            end
                            cnt_q <= '0; state_q <= S_B2D;
                        end
                        OP_MUL: begin
                            if (cnt_q != CW'(OPW)) begin
                                if (b_q[0]) acc_q <= acc_q + mc_q;
                                mc_q <= mc_q << 1;
                                b_q  <= b_q >> 1;
                            end else begin
                                bin_q <= acc_q; cnt_q <= '0; state_q <= S_B2D;
                            end
                        end
                        default: begin
                            if (cnt_q != CW'(OPW)) begin
                                acc_q <= {acc_q[RW-2:0], div_ge};
                                rem_q <= div_ge ? div_sub : div_sh[OPW-1:0];
                            end else if (b_q == '0) begin
                                err_q <= 1'b1; busy_q <= 1'b0; state_q <= S_SHOW;
                            end else begin
                                bin_q <= RW'(acc_q[OPW-1:0]);
`ifdef CALC_REMAINDER_EN
                                bin2_q <= RW'(rem_q);
`endif
                                cnt_q <= '0; state_q <= S_B2D;
                            end
                        end
                    endcase
                end
                S_B2D: begin
`ifdef CALC_REMAINDER_EN
                    bcd_q  <= dd_step(bcd_q, bin_q[RW-1], bin2_q[RW-1], op_q == 2'b11);
                    bin2_q <= bin2_q << 1;
`else
                    bcd_q  <= dd_step(bcd_q, 1'b0, bin_q[RW-1], 1'b0);
`endif
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(RW - 1)) begin
                        state_q <= S_SHOW; busy_q <= 1'b0;
                    end
                end
                default: state_q <= S_EDIT;
            endcase
        end
    end

    // Free-running refresh divider that advances the scanned digit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            refresh_q <= '0;
            scan_q    <= '0;
        end else if (refresh_q == RCW'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            scan_q    <= (scan_q == SCW'(ND - 1)) ? '0 : scan_q + SCW'(1);
        end else begin
            refresh_q <= refresh_q + RCW'(1);
        end
    end

    // Segment/anode drive: entered digits while editing, result in SHOW
    always_comb begin
        cur_digit = digits_q[{scan_q, 2'b00} +: 4];
        dash      = 1'b0;
        if (state_q == S_SHOW) begin
            cur_digit = bcd_q[{scan_q, 2'b00} +: 4];
            if (err_q) dash = 1'b1;
            else if (neg_q && scan_q == SCW'(ND - 1)) dash = 1'b1;
        end
        seg = dash ? SEG_DASH : seg_decode(cur_digit);
        an  = ~(ND'(1) << scan_q);
    end

    assign busy = busy_q;
    assign neg  = neg_q;
    assign err  = err_q;
endmodule

// File: tb/tb_seq_bcd_calculator.sv
// Bench for seq_bcd_calculator: directed and random calculations compared
// against an arithmetic reference model of the displayed result.
module tb_seq_bcd_calculator;
    localparam int OPD = 2;
    localparam int RD  = 4;
    localparam int SS  = 2;
    localparam int ND  = 2 * OPD;
    localparam int OPW = $clog2(10 ** OPD);
    localparam int RW  = 2 * OPW;
    localparam logic [6:0] DASH = 7'h3F;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [ND-1:0] in_r = '0;
    logic [1:0]    op_r = 2'b00;
    logic          go_r = 1'b0;
    logic          clr_r = 1'b0;
    logic          busy, neg, err;
    logic [6:0]    seg;
    logic [ND-1:0] an;

    int         n_checks = 0;
    int         n_fail = 0;
    int         dig[ND];
    logic [6:0] exp_q[$];

    seq_bcd_calculator #(.OP_DIGITS(OPD), .REFRESH_DIV(RD), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rstn(rstn), .in(in_r), .op(op_r), .go(go_r), .clr(clr_r),
        .busy(busy), .neg(neg), .err(err), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  default: return DASH;
        endcase
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [ND-1:0] m, input logic g, input logic c);
        in_r = m; go_r = g; clr_r = c;
        wait_cycles(SS + 1);
        in_r = '0; go_r = 1'b0; clr_r = 1'b0;
        wait_cycles(SS + 1);
    endtask

    // Clear, then bump each digit up to its target value
    task automatic enter(input int a, input int b);
        int v[ND];
        logic [ND-1:0] m;
        pulse('0, 1'b0, 1'b1);
        for (int i = 0; i < OPD; i++) begin
            v[i]       = (b / (10 ** i)) % 10;
            v[OPD + i] = (a / (10 ** i)) % 10;
        end
        for (int k = 0; k < 9; k++) begin
            m = '0;
            for (int i = 0; i < ND; i++) if (v[i] > k) m[i] = 1'b1;
            if (m != '0) pulse(m, 1'b0, 1'b0);
        end
        for (int i = 0; i < ND; i++) dig[i] = v[i];
    endtask

    task automatic load_exp_edit();
        exp_q.delete();
        for (int i = 0; i < ND; i++) exp_q.push_back(seg_of(dig[i]));
    endtask

    task automatic load_exp_result(input int res, input bit eneg, input bit eerr);
        exp_q.delete();
        for (int i = 0; i < ND; i++) begin
            if (eerr || (eneg && i == ND - 1)) exp_q.push_back(DASH);
            else exp_q.push_back(seg_of((res / (10 ** i)) % 10));
        end
    endtask

    // Observe a scan of all digits: segments, scan order and dwell time
    task automatic check_display(input string tag);
        bit seen[ND];
        int nseen, idx, prev, run, runs, bad_an;
        bit have_start;
        logic [ND-1:0] oh;
        nseen = 0; prev = -1; run = 0; runs = 0; bad_an = 0; have_start = 0;
        for (int i = 0; i < ND; i++) seen[i] = 0;
        for (int c = 0; c < (ND + 2) * RD && (nseen < ND || runs == 0); c++) begin
            @(negedge clk);
            idx = -1;
            for (int i = 0; i < ND; i++) begin
                oh = '1; oh[i] = 1'b0;
                if (an == oh) idx = i;
            end
            if (idx < 0) bad_an++;
            else begin
                if (!seen[idx]) begin
                    seen[idx] = 1; nseen++;
                    check($sformatf("%s seg%0d", tag, idx), seg, exp_q[idx]);
                end
                if (idx == prev) run++;
                else begin
                    if (have_start) begin
                        check($sformatf("%s dwell", tag), run, RD);
                        runs++;
                    end
                    if (prev >= 0) begin
                        check($sformatf("%s scan_order", tag), idx, (prev + 1) % ND);
                        have_start = 1;
                    end
                    run = 1; prev = idx;
                end
            end
        end
        check($sformatf("%s an_onehot", tag), bad_an, 0);
        check($sformatf("%s digits_seen", tag), nseen, ND);
    endtask

    task automatic run_op(input logic [1:0] opc, input int a, input int b, input bit glitch,
                          input string tag);
        int cnt, res, exp_lat;
        bit started, done, eneg, eerr;
        eneg = 0; eerr = 0; res = 0;
        case (opc)
            2'd0: res = a + b;
            2'd1: if (a < b) begin res = b - a; eneg = 1; end else res = a - b;
            2'd2: res = a * b;
            default: begin
                if (b == 0) eerr = 1;
                else begin
`ifdef CALC_REMAINDER_EN
                    res = (a / b) * (10 ** OPD) + (a % b);
`else
                    res = a / b;
`endif
                end
            end
        endcase
        exp_lat = opc[1] ? (2 + OPW + RW) : (2 + RW);
        op_r = opc; go_r = 1'b1; cnt = 0; started = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (c == SS + 1) go_r = 1'b0;
            if (glitch && c == 8) go_r = 1'b1;
            if (glitch && c == 12) go_r = 1'b0;
            if (busy) begin started = 1; cnt++; end
            else if (started) done = 1;
        end
        go_r = 1'b0;
        check({tag, " done"}, done, 1);
        if (!eerr) check({tag, " latency"}, cnt, exp_lat);
        check({tag, " neg"}, neg, eneg);
        check({tag, " err"}, err, eerr);
        load_exp_result(res, eneg, eerr);
        check_display(tag);
    endtask

    initial begin
        int a, b, cnt;
        logic [1:0] opc;
        wait_cycles(3);
        check("reset busy", busy, 0);
        check("reset neg", neg, 0);
        check("reset err", err, 0);
        check("reset an", an, 4'b1110);
        check("reset seg", seg, 7'h40);
        rstn = 1'b1;
        for (int i = 0; i < ND; i++) dig[i] = 0;
        load_exp_edit();
        check_display("idle");

        enter(12, 34);
        load_exp_edit();
        check_display("edit1234");
        run_op(2'd0, 12, 34, 0, "add");
        enter(99, 99);
        run_op(2'd2, 99, 99, 1, "mul");
        enter(12, 34);
        run_op(2'd1, 12, 34, 0, "sub");
        enter(47, 5);
        run_op(2'd3, 47, 5, 0, "div");
        enter(47, 0);
        run_op(2'd3, 47, 0, 0, "div0");

        // digit edge in SHOW clears err and returns to editing
        pulse(4'b0001, 1'b0, 1'b0);
        dig[0] = (dig[0] + 1) % 10;
        check("digit clears err", err, 0);
        load_exp_edit();
        check_display("after_err");

        // digit wrap 9 -> 0
        enter(0, 9);
        pulse(4'b0001, 1'b0, 1'b0);
        dig[0] = 0;
        load_exp_edit();
        check_display("wrap");

        for (int t = 0; t < 12; t++) begin
            a = $urandom_range(0, 10 ** OPD - 1);
            b = $urandom_range(0, 10 ** OPD - 1);
            opc = 2'($urandom_range(0, 3));
            enter(a, b);
            run_op(opc, a, b, 0, $sformatf("rnd%0d", t));
        end

        // clr in the middle of a multiply
        enter(99, 99);
        op_r = 2'd2; go_r = 1'b1;
        for (int c = 0; c < 10 && !busy; c++) @(negedge clk);
        check("clr busy seen", busy, 1);
        clr_r = 1'b1; go_r = 1'b0;
        wait_cycles(2);
        check("clr busy hold", busy, 1);
        wait_cycles(1);
        check("clr busy drop", busy, 0);
        clr_r = 1'b0;
        for (int i = 0; i < ND; i++) dig[i] = 0;
        wait_cycles(40);
        check("clr no restart", busy, 0);
        load_exp_edit();
        check_display("after_clr");

        // asynchronous reset during conversion
        enter(99, 99);
        op_r = 2'd2; go_r = 1'b1; cnt = 0;
        for (int c = 0; c < 40 && cnt < 15; c++) begin
            @(negedge clk);
            if (c == SS + 1) go_r = 1'b0;
            if (busy) cnt++;
        end
        go_r = 1'b0;
        check("b2d reached", cnt, 15);
        #2 rstn = 1'b0;
        #1;
        check("async busy", busy, 0);
        check("async neg", neg, 0);
        check("async err", err, 0);
        check("async an", an, 4'b1110);
        check("async seg", seg, 7'h40);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < ND; i++) dig[i] = 0;
        load_exp_edit();
        check_display("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
